// File: rtl/mem_responder_pkg.sv
// Shared memory map, status layout and UART shifter state type for the cpu RAM-port responder.
package mem_responder_pkg;

  localparam int MMIO_SEL = 29;

  localparam logic [3:0] OFF_TXDATA = 4'd0;
  localparam logic [3:0] OFF_STATUS = 4'd1;
  localparam logic [3:0] OFF_CYCLES = 4'd2;

  localparam int ST_FULL = 0;
  localparam int ST_BUSY = 1;
  localparam int ST_OVF  = 2;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  function automatic logic [31:0] status_word(input logic full, input logic busy, input logic ovf);
    logic [31:0] w;
    w          = '0;
    w[ST_FULL] = full;
    w[ST_BUSY] = busy;
    w[ST_OVF]  = ovf;
    return w;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// cpu RAM port: word address, read/write strobes, write data and registered read data.
interface mem_responder_if;
  logic [29:0] ram_addr;
  logic        ram_re;
  logic        ram_we;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  modport master (output ram_addr, ram_re, ram_we, ram_wdata, input ram_rdata);
  modport slave  (input ram_addr, ram_re, ram_we, ram_wdata, output ram_rdata);
endinterface

// File: rtl/mem_responder_uart_tx.sv
// 8N1 UART transmitter fed by a small circular byte FIFO; consecutive frames run back-to-back.
module uart_tx
  import mem_responder_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_AW      = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] din,
  output logic       full,
  output logic       busy,
  output logic       txd
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] COUNT_MAX = (FIFO_AW + 1)'(DEPTH);

  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               empty, fifo_full, pop, push_ok;

  tx_state_t     state, state_d;
  logic [CW-1:0] baud_cnt, baud_cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shreg, shreg_d;
  logic          bit_done;

  assign empty     = (count == '0);
  assign fifo_full = (count == COUNT_MAX);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted then.
  assign push_ok   = push && (!fifo_full || pop);
  assign full      = fifo_full && !pop;
  assign busy      = !empty || (state != TX_IDLE);
  assign bit_done  = (baud_cnt == BAUD_LAST);

  // NOTE: storage arrays carry no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)     rd_ptr <= rd_ptr + FIFO_AW'(1);
      count <= count + (FIFO_AW + 1)'(push_ok) - (FIFO_AW + 1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shreg    <= shreg_d;
    end
  end

  // NOTE: every output of this block gets a default first so no latch can be inferred.
  always_comb begin
    state_d    = state;
    baud_cnt_d = baud_cnt;
    bit_idx_d  = bit_idx;
    shreg_d    = shreg;
    pop        = 1'b0;
    txd        = 1'b1;
    unique case (state)
      TX_IDLE: begin
        baud_cnt_d = '0;
        if (!empty) begin
          pop       = 1'b1;
          shreg_d   = fifo_mem[rd_ptr];
          bit_idx_d = '0;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        txd = 1'b0;
        if (bit_done) begin
          baud_cnt_d = '0;
          state_d    = TX_DATA;
        end else begin
          baud_cnt_d = baud_cnt + CW'(1);
        end
      end
      TX_DATA: begin
        txd = shreg[bit_idx];
        if (bit_done) begin
          baud_cnt_d = '0;
          bit_idx_d  = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_d = TX_STOP;
        end else begin
          baud_cnt_d = baud_cnt + CW'(1);
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          baud_cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!empty) begin
            pop       = 1'b1;
            shreg_d   = fifo_mem[rd_ptr];
            bit_idx_d = '0;
            state_d   = TX_START;
          end else begin
            state_d   = TX_IDLE;
          end
        end else begin
          baud_cnt_d = baud_cnt + CW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

endmodule

// File: rtl/mem_responder.sv
// Zero-wait RAM-port responder: word RAM plus MMIO UART TX, status and free-running cycle counter.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int RAM_AW       = 10,
  parameter int CLKS_PER_BIT = 104,
  parameter int FIFO_AW      = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  mem_responder_if.slave  bus,
  output logic            uart_txd
);

  logic [31:0]       ram [2 ** RAM_AW];
  logic [RAM_AW-1:0] ram_idx;
  logic [3:0]        offset;
  logic              mmio_sel;
  logic              tx_push, tx_full, tx_busy, status_rd;
  logic              overflow;
  logic [31:0]       cycles;
  logic [31:0]       mmio_rdata;

  assign mmio_sel  = bus.ram_addr[MMIO_SEL];
  assign ram_idx   = bus.ram_addr[RAM_AW-1:0];
  assign offset    = bus.ram_addr[3:0];
  assign tx_push   = bus.ram_we && mmio_sel && (offset == OFF_TXDATA);
  assign status_rd = bus.ram_re && mmio_sel && (offset == OFF_STATUS);

  uart_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .FIFO_AW      (FIFO_AW)
  ) u_uart_tx (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (tx_push),
    .din     (bus.ram_wdata[7:0]),
    .full    (tx_full),
    .busy    (tx_busy),
    .txd     (uart_txd)
  );

  always_ff @(posedge clk) begin
    if (bus.ram_we && !mmio_sel) ram[ram_idx] <= bus.ram_wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cycles <= '0;
    else          cycles <= cycles + 32'd1;
  end

  // A dropped byte in the same cycle as a STATUS read keeps the flag set, so no drop goes unseen.
  always_ff @(posedge clk) begin
    if (!reset_n)                overflow <= 1'b0;
    else if (tx_push && tx_full) overflow <= 1'b1;
    else if (status_rd)          overflow <= 1'b0;
  end

  always_comb begin
    mmio_rdata = '0;
    unique case (offset)
      OFF_STATUS: mmio_rdata = status_word(tx_full, tx_busy, overflow);
      OFF_CYCLES: mmio_rdata = cycles;
      default:    mmio_rdata = '0;
    endcase
  end

  // Reads sample pre-edge state, giving read-first RAM and pre-write/pre-clear MMIO values.
  always_ff @(posedge clk) begin
    if (!reset_n)        bus.ram_rdata <= '0;
    else if (bus.ram_re) bus.ram_rdata <= mmio_sel ? mmio_rdata : ram[ram_idx];
  end

endmodule
